// File: rtl/arb_mux_nx_pkg.sv
// Shared definitions for the arb_mux_nx N:1 bus selector.
// Covers the mode encodings and the select-width helper.
package arb_mux_nx_pkg;

  typedef enum logic [0:0] {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned MIN_N = 2;
  localparam int unsigned MAX_N = 16;

  // Select/index width for an N-channel selector; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_nx_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the slot after ptr is
// at bit 0, pick the lowest set bit, then rotate the index back.
module arb_mux_nx_rr_arbiter
  import arb_mux_nx_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // One extra bit so start + offset never overflows before the modulo.
  localparam int unsigned IW = SEL_W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  start;
  logic [IW-1:0]  first;
  logic [IW-1:0]  sum;

  always_comb begin
    start = (IW'(ptr) == IW'(N - 1)) ? '0 : IW'(ptr) + IW'(1);
    dbl   = {req, req};
    rot   = N'(dbl >> start);
    first = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) first = IW'(k);
    end
    sum     = start + first;
    gnt_idx = (sum >= IW'(N)) ? SEL_W'(sum - IW'(N)) : SEL_W'(sum);
    any     = |req;
  end

endmodule

// File: rtl/arb_mux_nx.sv
// N:1 bus selector with per-channel valid/ready and a registered output slot.
// MODE 0 picks the channel from sel; MODE 1 arbitrates round-robin.
module arb_mux_nx
  import arb_mux_nx_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 8,
  parameter  int unsigned MODE  = 0,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             load_en;
  logic             req_ok;
  logic             xfer;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_data;

  // Slot is free when empty or drained this cycle; reset blocks any acceptance.
  assign load_en = ~rst & (~out_valid | out_ready);
  assign xfer    = load_en & req_ok;

  generate
    if (MODE == int'(MODE_RR)) begin : g_rr
      logic [SEL_W-1:0] rr_ptr;
      logic [SEL_W-1:0] rr_gnt;
      logic             rr_any;
      logic             unused_sel;

      assign unused_sel = ^sel;

      arb_mux_nx_rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_gnt),
        .any     (rr_any)
      );

      assign gnt    = rr_gnt;
      assign req_ok = rr_any;

      // Fairness pointer moves only on an accepted beat.
      always_ff @(posedge clk) begin
        if (rst)       rr_ptr <= SEL_W'(N - 1);
        else if (xfer) rr_ptr <= gnt;
      end
    end else begin : g_fixed
      // Out-of-range selects match no channel and so never request.
      always_comb begin
        req_ok = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
          if (sel == SEL_W'(i)) req_ok = in_valid[i];
        end
      end

      assign gnt = sel;
    end
  endgenerate

  assign gnt_data = in_data[gnt*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_ready[i] = xfer & (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (req_ok) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
